// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction fetch sequencer feeding decode through a small FIFO
// Optional FETCH_PERF_EN adds a saturating enqueue counter on perf_fetch_cnt.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] LIMIT    = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_idle,
    output logic [31:0] perf_fetch_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_pc_mem   [DEPTH];
    logic [31:0]   r_data_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic [31:0]   w_fetch_pc_inc;
    logic [31:0]   w_redirect_pc;
    logic          w_full;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_push;

    assign w_fetch_pc_inc = r_fetch_pc + 32'd4;
    assign w_redirect_pc  = redirect_pc & ~32'h0000_0003;
    assign w_full         = (r_count == CNT_FULL);
    assign w_pop          = instr_valid && instr_ready;
    assign w_push_ok      = !w_full || w_pop;
    assign w_push         = (r_state == ST_RUN) && w_push_ok && !redirect_valid;

    assign imem_addr   = r_fetch_pc;
    assign instr_valid = (r_count != '0);
    assign instr_data  = instr_valid ? r_data_mem[r_rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? r_pc_mem[r_rd_ptr]   : 32'h0;
    assign fetch_idle  = (r_state == ST_BOOT) || (r_state == ST_DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = (w_redirect_pc >= LIMIT) ? ST_DRAIN : ST_RUN;
        end else begin
            case (r_state)
                ST_BOOT:  w_state_nxt = ST_RUN;
                ST_RUN:   if (w_push && (w_fetch_pc_inc == LIMIT)) w_state_nxt = ST_DRAIN;
                ST_DRAIN: w_state_nxt = ST_DRAIN;
                default:  w_state_nxt = ST_BOOT;
            endcase
        end
    end

    // A redirect flushes everything; a handshake in the same cycle is simply absorbed by the flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= w_fetch_pc_inc;
                r_wr_ptr   <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
            r_data_mem[r_wr_ptr] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cnt <= 32'h0;
        end else if (w_push && (r_perf_cnt != 32'hFFFF_FFFF)) begin
            r_perf_cnt <= r_perf_cnt + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_perf_cnt;
`else
    assign perf_fetch_cnt = 32'h0;
`endif

endmodule
